bcd_to_bin_seq: RTL and testbench

- Sequential decimal-to-binary converter: the inverse path of the binary-to-4-digit BCD display chain.
- Accepts N_DIG packed BCD digits, e.g. from keypad/switch entry, and produces the binary value with a start/busy/done handshake.
- Iterative multiply-by-10-and-add, one digit per clock, most significant digit first.
- Sits between digit entry logic and binary datapaths such as counters and comparators.

---
 rtl/bcd_to_bin_seq.sv | 79 +++++++
 tb/tb_bcd_to_bin_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: MSD-first multiply-by-10 BCD to binary converter; define BCD2BIN_SAT_EN to saturate on overflow
module bcd_to_bin_seq #(
  parameter int N_DIG = 4,
  parameter int N_OUT = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*N_DIG-1:0] bcd_in,
  output logic               busy,
  output logic               done,
  output logic [N_OUT-1:0]   bin_out,
  output logic               err,
  output logic               ovf
);
  localparam int CW = $clog2(N_DIG + 1);
  localparam logic [N_OUT+3:0] TEN = (N_OUT + 4)'(10);
  localparam logic [N_OUT+3:0] MAX = {4'b0, {N_OUT{1'b1}}};
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nxt;
  logic [4*N_DIG-1:0] sr;
  logic [N_OUT-1:0] acc, res;
  logic [CW-1:0] cnt;
  logic err_int, ovf_int;
  logic [3:0] dig;
  logic [N_OUT+3:0] step;
  assign dig = sr[4*N_DIG-1 -: 4];
  assign step = {4'b0, acc} * TEN + {{N_OUT{1'b0}}, dig};
`ifdef BCD2BIN_SAT_EN
  assign res = ovf_int ? '1 : acc;
`else
  assign res = acc;
`endif
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? CONV : IDLE)
              : (state == CONV) ? ((cnt == CW'(N_DIG - 1)) ? DONE : CONV)
              : IDLE;
  end
  // busy/done are registered from the state, so done lands one edge after the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_int <= 1'b0;
      ovf_int <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= state != IDLE;
      done  <= state == DONE;
      if (state == IDLE && start) begin
        sr      <= bcd_in;
        acc     <= '0;
        cnt     <= '0;
        err_int <= 1'b0;
        ovf_int <= 1'b0;
      end
      if (state == CONV) begin
        sr      <= sr << 4;
        acc     <= step[N_OUT-1:0];
        cnt     <= cnt + CW'(1);
        err_int <= err_int | (dig > 4'd9);
        ovf_int <= ovf_int | (step > MAX);
      end
      if (state == DONE) begin
        err     <= err_int;
        ovf     <= ovf_int;
        bin_out <= err_int ? '0 : res;
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: randomized checks of two converter widths against an arithmetic reference model
module tb_bcd_to_bin_seq;
  localparam int N_DIG = 4;
  logic clk, rst_n, start;
  logic [15:0] bcd_in;
  logic busy0, done0, err0, ovf0, busy1, done1, err1, ovf1;
  logic [13:0] bin0;
  logic [9:0] bin1;
  int cmp = 0, bad = 0;

  bcd_to_bin_seq #(.N_DIG(4), .N_OUT(14)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy0), .done(done0), .bin_out(bin0), .err(err0), .ovf(ovf0));
  bcd_to_bin_seq #(.N_DIG(4), .N_OUT(10)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy1), .done(done1), .bin_out(bin1), .err(err1), .ovf(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input logic [15:0] bcd, input int w,
                       output logic [13:0] eb, output logic ee, output logic eo);
    int v, d;
    v = 0;
    ee = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = int'(bcd[4*k +: 4]);
      v += d * (10 ** k);
      if (d > 9) ee = 1'b1;
    end
    eo = v > (1 << w) - 1;
`ifdef BCD2BIN_SAT_EN
    eb = ee ? 14'd0 : eo ? 14'((1 << w) - 1) : 14'(v % (1 << w));
`else
    eb = ee ? 14'd0 : 14'(v % (1 << w));
`endif
  endtask

  task automatic do_conv(input logic [15:0] bcd, input bit intrude);
    logic [13:0] eb0, eb1;
    logic ee0, eo0, ee1, eo1;
    bit exp_busy, exp_done;
    model(bcd, 14, eb0, ee0, eo0);
    model(bcd, 10, eb1, ee1, eo1);
    @(negedge clk);
    start = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    #1;
    cmp++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL edge_t busy=%b done=%b required busy=0 done=0", busy0, done0);
    end
    @(negedge clk);
    start = 1'b0;
    bcd_in = 16'($urandom);
    for (int i = 1; i <= N_DIG + 4; i++) begin
      @(posedge clk);
      #1;
      exp_busy = (i >= 1 && i <= N_DIG + 1);
      exp_done = (i == N_DIG + 1);
      cmp++;
      if (busy0 !== exp_busy || busy1 !== exp_busy) begin
        bad++;
        $display("FAIL busy bcd=%h i=%0d got %b/%b required %b", bcd, i, busy0, busy1, exp_busy);
      end
      cmp++;
      if (done0 !== exp_done || done1 !== exp_done) begin
        bad++;
        $display("FAIL done bcd=%h i=%0d got %b/%b required %b", bcd, i, done0, done1, exp_done);
      end
      if (i == N_DIG + 1 || i == N_DIG + 4) begin
        cmp++;
        if (bin0 !== eb0 || err0 !== ee0 || ovf0 !== eo0) begin
          bad++;
          $display("FAIL result14 bcd=%h i=%0d got bin=%0d err=%b ovf=%b required bin=%0d err=%b ovf=%b",
                   bcd, i, bin0, err0, ovf0, eb0, ee0, eo0);
        end
        cmp++;
        if (bin1 !== eb1[9:0] || err1 !== ee1 || ovf1 !== eo1) begin
          bad++;
          $display("FAIL result10 bcd=%h i=%0d got bin=%0d err=%b ovf=%b required bin=%0d err=%b ovf=%b",
                   bcd, i, bin1, err1, ovf1, eb1[9:0], ee1, eo1);
        end
      end
      if (intrude && i == 1) begin
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h0777;
      end
      if (intrude && i == 2) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    bcd_in = 16'h0000;
    #1;
    cmp++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || bin0 !== 14'd0 || err0 !== 1'b0 || ovf0 !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || bin1 !== 10'd0 || err1 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL reset got busy=%b done=%b bin=%0d/%0d err=%b ovf=%b required all zero",
               busy0, done0, bin0, bin1, err0, ovf0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    do_conv(16'h1234, 0);
    do_conv(16'h9999, 0);
    do_conv(16'h0000, 0);
    do_conv(16'h1023, 0);
    do_conv(16'h12A3, 0);
    do_conv(16'h0042, 0);
  endtask

  task automatic test_random;
    logic [15:0] b;
    repeat (12) begin
      for (int k = 0; k < 4; k++)
        b[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      do_conv(b, 0);
    end
  endtask

  task automatic test_ignored_start;
    do_conv(16'h0005, 1);
  endtask

  task automatic test_abort;
    @(negedge clk);
    start = 1'b1;
    bcd_in = 16'h4321;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cmp++;
    if (busy0 !== 1'b0 || bin0 !== 14'd0 || busy1 !== 1'b0 || bin1 !== 10'd0 || err0 !== 1'b0 || ovf0 !== 1'b0) begin
      bad++;
      $display("FAIL abort got busy=%b/%b bin=%0d/%0d required busy=0 bin=0", busy0, busy1, bin0, bin1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      cmp++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet i=%0d got done=%b/%b busy=%b required 0", i, done0, done1, busy0);
      end
    end
    do_conv(16'h0100, 0);
  endtask

  task automatic test_back_to_back;
    int dones[$];
    @(negedge clk);
    start = 1'b1;
    bcd_in = 16'h0777;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        dones.push_back(i);
        cmp++;
        if (bin0 !== 14'd777 || bin1 !== 10'd777) begin
          bad++;
          $display("FAIL b2b_value i=%0d got %0d/%0d required 777", i, bin0, bin1);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    cmp++;
    if (dones.size() != 5) begin
      bad++;
      $display("FAIL b2b_count got %0d required 5", dones.size());
    end
    for (int j = 0; j < dones.size(); j++) begin
      cmp++;
      if (dones[j] != 6 * (j + 1)) begin
        bad++;
        $display("FAIL b2b_timing idx=%0d got edge %0d required %0d", j, dones[j], 6 * (j + 1));
      end
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
